branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
Sequencing controller for the shared branch comparator in the RISC-V core.
- Accepts one branch request per handshake and latches its operands.
- Drives the external comparator with the operands and compare-mode select, samples its equal/less-than results one cycle later, and resolves taken/not-taken per funct3.
- Returns the next PC to the PC-select logic through a valid/ready response handshake.

Parameters:
XLEN, 32, datapath width of pc, imm, operands and next_pc

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  branch request present
req_ready  output  1  controller can accept a request
req_funct3  input  3  branch funct3 field
req_pc  input  XLEN  PC of the branch instruction
req_imm  input  XLEN  sign-extended B-type immediate
req_rs1  input  XLEN  rs1 operand
req_rs2  input  XLEN  rs2 operand
cmp_a  output  XLEN  comparator operand A (latched rs1)
cmp_b  output  XLEN  comparator operand B (latched rs2)
cmp_brun  output  1  comparator mode: 1 = signed (BLT/BGE), 0 = unsigned/equality
cmp_eq  input  1  comparator equal result
cmp_lt  input  1  comparator less-than result
resp_valid  output  1  resolution available
resp_ready  input  1  consumer accepts resolution
resp_taken  output  1  branch taken
resp_next_pc  output  XLEN  resolved next PC
resp_illegal  output  1  funct3 not a branch encoding
resp_misalign  output  1  taken target not 4-byte aligned

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE.
  - resp_valid, resp_taken, resp_illegal, resp_misalign = 0.
  - resp_next_pc, cmp_a, cmp_b = 0; cmp_brun = 0; req_ready = 0 while rst_n is low.
  - Any in-flight request is discarded.
- FSM states: IDLE, CMP, RESP.
  - IDLE: req_ready = 1. On req_valid & req_ready at edge N, latch funct3/pc/imm/rs1/rs2 and go to CMP.
  - CMP: cmp_a/cmp_b hold the latched operands; cmp_brun = 1 for funct3 100/101, else 0. At edge N+1, sample cmp_eq/cmp_lt, compute and register the response, go to RESP.
  - RESP: resp_valid = 1 starting the cycle after edge N+1. Hold all resp_* stable until resp_ready. On resp_valid & resp_ready, go to IDLE.
- req_ready is 0 in CMP and RESP; there are no back-to-back overlapping requests.
- Minimum request-to-response latency is 2 edges.
- Throughput is one branch per 3 cycles when resp_ready is held high.
- Taken decode:
  - 000 BEQ: taken = eq
  - 001 BNE: taken = !eq
  - 100 BLT: taken = lt
  - 101 BGE: taken = !lt
  - 110 BLTU: taken = lt
  - 111 BGEU: taken = !lt
  - 010/011: taken = 0, resp_illegal = 1
- resp_next_pc = taken ? pc + imm : pc + 4. Arithmetic is modulo 2^XLEN; wrap-around is silent.
- resp_misalign = taken & (pc + imm)[1:0] != 0. next_pc still carries the unaligned target.
- cmp_a/cmp_b hold their last latched value outside CMP; they are not cleared on return to IDLE.
- req_valid while not ready is ignored and not queued. The requester must hold it.
- resp_ready asserted without resp_valid: no effect.
- rst_n low in CMP or RESP: immediate return to IDLE with outputs cleared. The response is lost.

Optional Feature:
Macro BRANCH_CTRL_STATS_EN.
- Defined:
  - Adds outputs stat_branches (32) and stat_taken (32).
  - stat_branches increments on each completed response handshake.
  - stat_taken increments on a completed handshake with resp_taken = 1.
  - Illegal requests count in stat_branches only.
  - Both counters saturate at 0xFFFFFFFF and reset to 0 on rst_n.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then BEQ with pc=0x100, imm=0x20, rs1=rs2=5, comparator model connected, resp_ready=1 → resp_valid 2 edges after accept, taken=1, next_pc=0x120, cmp_brun=0.
- BLT with rs1=0xFFFFFFFF, rs2=1 → cmp_brun=1, taken=1. BLTU with the same operands → cmp_brun=0, taken=0, next_pc=pc+4.
- BNE with pc=0xFFFFFFFC, imm=0x8, rs1=1, rs2=2 → taken=1, next_pc=0x00000004 (wrap).
- funct3=011 → resp_illegal=1, taken=0, next_pc=pc+4. BEQ with imm=0x2, equal operands → resp_misalign=1.
- resp_ready held 0 for 5 cycles → resp_* stable and req_ready=0. A new req_valid in that window is not accepted until the cycle after the response handshake.
- Assert rst_n low during CMP → resp_valid stays 0, FSM in IDLE. With BRANCH_CTRL_STATS_EN defined, 3 taken + 2 not-taken completed branches → stat_branches=5, stat_taken=3.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: request, comparator and response signals of the branch
// controller. The slave modport is the controller's view. The master modport
// is the environment's view: the requester, the external comparator and the
// PC-select consumer.
interface branch_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_imm;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;

    logic [XLEN-1:0] cmp_a;
    logic [XLEN-1:0] cmp_b;
    logic            cmp_brun;
    logic            cmp_eq;
    logic            cmp_lt;

    logic            resp_valid;
    logic            resp_ready;
    logic            resp_taken;
    logic [XLEN-1:0] resp_next_pc;
    logic            resp_illegal;
    logic            resp_misalign;

    modport slave (
        input  req_valid, req_funct3, req_pc, req_imm, req_rs1, req_rs2,
        input  cmp_eq, cmp_lt, resp_ready,
        output req_ready, cmp_a, cmp_b, cmp_brun,
        output resp_valid, resp_taken, resp_next_pc, resp_illegal, resp_misalign
    );

    modport master (
        output req_valid, req_funct3, req_pc, req_imm, req_rs1, req_rs2,
        output cmp_eq, cmp_lt, resp_ready,
        input  req_ready, cmp_a, cmp_b, cmp_brun,
        input  resp_valid, resp_taken, resp_next_pc, resp_illegal, resp_misalign
    );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: sequencing controller for the shared branch comparator.
// IDLE accepts and latches a request, CMP presents the operands to the
// external comparator and registers the resolution, RESP holds the result
// until the consumer takes it.
// Optional feature macro: BRANCH_CTRL_STATS_EN adds saturating counters
// stat_branches / stat_taken.
module branch_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    branch_ctrl_if.slave bus
`ifdef BRANCH_CTRL_STATS_EN
    ,
    output logic [31:0]  stat_branches,
    output logic [31:0]  stat_taken
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        RESP
    } state_t;

    state_t          state;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;

    logic [XLEN-1:0] target;
    logic [XLEN-1:0] seq_pc;
    logic            taken;
    logic            illegal;

    // Resolve taken/illegal from the latched funct3 and the live comparator results
    always_comb begin
        target  = pc_q + imm_q;
        seq_pc  = pc_q + XLEN'(4);
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3_q)
            3'b000:  taken = bus.cmp_eq;
            3'b001:  taken = !bus.cmp_eq;
            3'b100:  taken = bus.cmp_lt;
            3'b101:  taken = !bus.cmp_lt;
            3'b110:  taken = bus.cmp_lt;
            3'b111:  taken = !bus.cmp_lt;
            default: illegal = 1'b1;
        endcase
    end

    // Controller FSM with registered handshake, comparator and response outputs.
    // req_ready is registered, so it rises on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            funct3_q          <= '0;
            pc_q              <= '0;
            imm_q             <= '0;
            bus.req_ready     <= 1'b0;
            bus.cmp_a         <= '0;
            bus.cmp_b         <= '0;
            bus.cmp_brun      <= 1'b0;
            bus.resp_valid    <= 1'b0;
            bus.resp_taken    <= 1'b0;
            bus.resp_next_pc  <= '0;
            bus.resp_illegal  <= 1'b0;
            bus.resp_misalign <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        funct3_q      <= bus.req_funct3;
                        pc_q          <= bus.req_pc;
                        imm_q         <= bus.req_imm;
                        bus.cmp_a     <= bus.req_rs1;
                        bus.cmp_b     <= bus.req_rs2;
                        bus.cmp_brun  <= (bus.req_funct3[2:1] == 2'b10);
                        bus.req_ready <= 1'b0;
                        state         <= CMP;
                    end
                end
                CMP: begin
                    bus.resp_taken    <= taken;
                    bus.resp_next_pc  <= taken ? target : seq_pc;
                    bus.resp_illegal  <= illegal;
                    bus.resp_misalign <= taken && (target[1:0] != 2'b00);
                    bus.resp_valid    <= 1'b1;
                    bus.cmp_brun      <= 1'b0;
                    state             <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BRANCH_CTRL_STATS_EN
    // Saturating counts of completed response handshakes and taken resolutions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches <= '0;
            stat_taken    <= '0;
        end else if (bus.resp_valid && bus.resp_ready) begin
            if (stat_branches != '1) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (bus.resp_taken && (stat_taken != '1)) begin
                stat_taken <= stat_taken + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: scoreboard bench for branch_ctrl. Directed requests push
// hand-computed responses into a queue; a monitor pops and compares on every
// response handshake. A behavioural comparator drives cmp_eq/cmp_lt.
module tb_branch_ctrl;

    logic clk;
    logic rst_n;

    branch_ctrl_if #(.XLEN(32)) bus ();

`ifdef BRANCH_CTRL_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_taken;
`endif

    branch_ctrl #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BRANCH_CTRL_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_taken    (stat_taken)
`endif
    );

    // External comparator model
    assign bus.cmp_eq = (bus.cmp_a == bus.cmp_b);
    assign bus.cmp_lt = bus.cmp_brun ? ($signed(bus.cmp_a) < $signed(bus.cmp_b))
                                     : (bus.cmp_a < bus.cmp_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        taken;
        logic [31:0] next_pc;
        logic        illegal;
        logic        misalign;
    } resp_t;

    resp_t       exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare on each response handshake
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_resp: got next_pc 0x%08h, expected no response", bus.resp_next_pc);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                chk("resp_taken",    32'(bus.resp_taken),    32'(e.taken));
                chk("resp_next_pc",  bus.resp_next_pc,       e.next_pc);
                chk("resp_illegal",  32'(bus.resp_illegal),  32'(e.illegal));
                chk("resp_misalign", 32'(bus.resp_misalign), 32'(e.misalign));
            end
        end
    end

    task automatic wait_ready();
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic drive_req(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                             input logic [31:0] rs1, input logic [31:0] rs2);
        bus.req_funct3 = f3;
        bus.req_pc     = pc;
        bus.req_imm    = imm;
        bus.req_rs1    = rs1;
        bus.req_rs2    = rs2;
        bus.req_valid  = 1'b1;
    endtask

    // Issue one request and check the CMP cycle and the 2-edge response latency
    task automatic issue(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic brun,
                         input logic taken, input logic [31:0] npc, input logic ill, input logic mis);
        resp_t e;
        wait_ready();
        drive_req(f3, pc, imm, rs1, rs2);
        e.taken = taken; e.next_pc = npc; e.illegal = ill; e.misalign = mis;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        chk("cmp_a",          bus.cmp_a,              rs1);
        chk("cmp_b",          bus.cmp_b,              rs2);
        chk("cmp_brun",       32'(bus.cmp_brun),      32'(brun));
        chk("req_ready_cmp",  32'(bus.req_ready),     32'd0);
        chk("resp_valid_cmp", 32'(bus.resp_valid),    32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("resp_valid_lat", 32'(bus.resp_valid),    32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_funct3 = '0;
        bus.req_pc     = '0;
        bus.req_imm    = '0;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.resp_ready = 1'b1;

        #12;
        chk("rst_req_ready",  32'(bus.req_ready),     32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid),    32'd0);
        chk("rst_resp_taken", 32'(bus.resp_taken),    32'd0);
        chk("rst_next_pc",    bus.resp_next_pc,       32'd0);
        chk("rst_illegal",    32'(bus.resp_illegal),  32'd0);
        chk("rst_misalign",   32'(bus.resp_misalign), 32'd0);
        chk("rst_cmp_a",      bus.cmp_a,              32'd0);
        chk("rst_cmp_b",      bus.cmp_b,              32'd0);
        chk("rst_cmp_brun",   32'(bus.cmp_brun),      32'd0);
`ifdef BRANCH_CTRL_STATS_EN
        chk("rst_stat_branches", stat_branches, 32'd0);
        chk("rst_stat_taken",    stat_taken,    32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        //    f3      pc            imm           rs1           rs2           brun  tk    next_pc       ill   mis
        issue(3'b000, 32'h0000_0100, 32'h0000_0020, 32'd5,        32'd5,        1'b0, 1'b1, 32'h0000_0120, 1'b0, 1'b0);
        issue(3'b100, 32'h0000_0200, 32'h0000_0040, 32'hFFFF_FFFF, 32'd1,        1'b1, 1'b1, 32'h0000_0240, 1'b0, 1'b0);
        issue(3'b110, 32'h0000_0200, 32'h0000_0040, 32'hFFFF_FFFF, 32'd1,        1'b0, 1'b0, 32'h0000_0204, 1'b0, 1'b0);
        issue(3'b001, 32'hFFFF_FFFC, 32'h0000_0008, 32'd1,        32'd2,        1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0);
        issue(3'b011, 32'h0000_0300, 32'h0000_0010, 32'd1,        32'd1,        1'b0, 1'b0, 32'h0000_0304, 1'b1, 1'b0);
        issue(3'b010, 32'h0000_0700, 32'h0000_0010, 32'd4,        32'd4,        1'b0, 1'b0, 32'h0000_0704, 1'b1, 1'b0);
        issue(3'b000, 32'h0000_0400, 32'h0000_0002, 32'd7,        32'd7,        1'b0, 1'b1, 32'h0000_0402, 1'b0, 1'b1);
        issue(3'b001, 32'h0000_0400, 32'h0000_0002, 32'd7,        32'd7,        1'b0, 1'b0, 32'h0000_0404, 1'b0, 1'b0);
        issue(3'b101, 32'h0000_0500, 32'hFFFF_FFF0, 32'd3,        32'hFFFF_FFFE, 1'b1, 1'b1, 32'h0000_04F0, 1'b0, 1'b0);
        issue(3'b111, 32'h0000_0600, 32'h0000_0100, 32'd1,        32'd2,        1'b0, 1'b0, 32'h0000_0604, 1'b0, 1'b0);

        // Back-pressure: response held for 5 cycles while a new request waits
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        issue(3'b000, 32'h0000_0800, 32'h0000_0010, 32'd9, 32'd9, 1'b0, 1'b1, 32'h0000_0810, 1'b0, 1'b0);
        begin
            resp_t e;
            drive_req(3'b001, 32'h0000_0900, 32'h0000_0020, 32'd9, 32'd9);
            e.taken = 1'b0; e.next_pc = 32'h0000_0904; e.illegal = 1'b0; e.misalign = 1'b0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("stall_taken",      32'(bus.resp_taken), 32'd1);
            chk("stall_next_pc",    bus.resp_next_pc,    32'h0000_0810);
            chk("stall_req_ready",  32'(bus.req_ready),  32'd0);
            chk("stall_cmp_a_held", bus.cmp_a,           32'd9);
        end
        @(posedge clk);
        #1 bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("hs_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("post_hs_req_ready",  32'(bus.req_ready),  32'd1);
        chk("post_hs_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        chk("held_req_cmp_a",     bus.cmp_a,           32'd9);
        chk("held_req_ready",     32'(bus.req_ready),  32'd0);
        chk("held_req_resp_valid", 32'(bus.resp_valid), 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("held_req_lat", 32'(bus.resp_valid), 32'd1);

        // Reset while in CMP: the response is lost
        wait_ready();
        drive_req(3'b000, 32'h0000_0A00, 32'h0000_0040, 32'd3, 32'd3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("rstcmp_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rstcmp_req_ready",  32'(bus.req_ready),  32'd0);
        chk("rstcmp_cmp_a",      bus.cmp_a,           32'd0);
        chk("rstcmp_cmp_brun",   32'(bus.cmp_brun),   32'd0);
        chk("rstcmp_next_pc",    bus.resp_next_pc,    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstcmp_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        chk("rstcmp_idle_ready", 32'(bus.req_ready), 32'd1);

        // 3 taken + 2 not-taken after reset
        issue(3'b000, 32'h0000_0100, 32'h0000_0020, 32'd5,        32'd5, 1'b0, 1'b1, 32'h0000_0120, 1'b0, 1'b0);
        issue(3'b110, 32'h0000_0200, 32'h0000_0040, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0204, 1'b0, 1'b0);
        issue(3'b100, 32'h0000_0200, 32'h0000_0040, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 32'h0000_0240, 1'b0, 1'b0);
        issue(3'b111, 32'h0000_0600, 32'h0000_0100, 32'd1,        32'd2, 1'b0, 1'b0, 32'h0000_0604, 1'b0, 1'b0);
        issue(3'b001, 32'hFFFF_FFFC, 32'h0000_0008, 32'd1,        32'd2, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0);
        @(negedge clk);
        chk("final_resp_valid", 32'(bus.resp_valid), 32'd0);
`ifdef BRANCH_CTRL_STATS_EN
        chk("stat_branches", stat_branches, 32'd5);
        chk("stat_taken",    stat_taken,    32'd3);
`endif
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
